neuron_update_seq: RTL and testbench

NEURON_UPDATE_SEQ -- requirements
Module: neuron_update_seq

---
 rtl/neuron_update_seq.sv | 95 +++++++++
 tb/tb_neuron_update_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/neuron_update_seq.sv
// neuron_update_seq: sequential leaky integrate-and-fire update of one neuron potential
//   clk, rst              : clock, asynchronous active-high reset
//   start, stored_v       : begin an update from the stored potential
//   in_valid, in_weight,
//   in_ready              : weight stream, N_INPUTS handshakes per update
//   upd_q, upd_set        : new potential and one-cycle load strobe to the storage register
//   spike                 : fire pulse, coincident with upd_set
//   busy                  : update in progress
module neuron_update_seq #(
    parameter int WIDTH      = 21,
    parameter int N_INPUTS   = 4,
    parameter int LEAK_SHIFT = 4,
    parameter int THRESHOLD  = 7680
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] stored_v,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_weight,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] upd_q,
    output logic                    upd_set,
    output logic                    spike,
    output logic                    busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] LEAK  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;
    localparam int CW = $clog2(N_INPUTS + 1);
    localparam logic signed [WIDTH:0]   MAXV = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0]   MINV = {2'b11, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] THR  = WIDTH'(THRESHOLD);
    localparam logic [CW-1:0]           LAST = CW'(N_INPUTS - 1);

    logic [1:0]              state;
    logic signed [WIDTH-1:0] acc;
    logic [CW-1:0]           count;
    logic signed [WIDTH:0]   sum_w;
    logic signed [WIDTH:0]   sum_l;
    logic                    fire;

    // Sums carry one guard bit so overflow is visible before clamping.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH:0] x);
        return x > MAXV ? MAXV[WIDTH-1:0] : x < MINV ? MINV[WIDTH-1:0] : x[WIDTH-1:0];
    endfunction

    always_comb begin
        sum_w = $signed({acc[WIDTH-1], acc}) + $signed({in_weight[WIDTH-1], in_weight});
        sum_l = $signed({acc[WIDTH-1], acc}) - $signed({acc[WIDTH-1], acc >>> LEAK_SHIFT});
        fire  = acc >= THR;
    end

    assign in_ready = state == ACCUM;
    assign busy     = state != IDLE;

    // Result registers load on the edge leaving WRITE, so upd_set lands two
    // edges after the last accepted weight and drops on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            upd_q   <= '0;
            upd_set <= 1'b0;
            spike   <= 1'b0;
        end else begin
            upd_set <= 1'b0;
            spike   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    acc   <= stored_v;
                    count <= '0;
                    state <= ACCUM;
                end
                ACCUM: if (in_valid) begin
                    acc   <= sat(sum_w);
                    count <= count + 1'b1;
                    state <= count == LAST ? LEAK : ACCUM;
                end
                LEAK: begin
                    acc   <= sat(sum_l);
                    state <= WRITE;
                end
                default: begin
                    upd_set <= 1'b1;
                    spike   <= fire;
                    upd_q   <= fire ? '0 : acc;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_update_seq.sv
// tb_neuron_update_seq: directed table-driven bench for neuron_update_seq
module tb_neuron_update_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic signed [20:0] stored_v = '0;
    logic in_valid = 1'b0;
    logic signed [20:0] in_weight = '0;
    logic in_ready;
    logic signed [20:0] upd_q;
    logic upd_set;
    logic spike;
    logic busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic signed [20:0] sv;
        logic signed [20:0] w;
        logic signed [20:0] q;
        logic               spk;
    } vec_t;

    neuron_update_seq dut (
        .clk(clk), .rst(rst), .start(start), .stored_v(stored_v),
        .in_valid(in_valid), .in_weight(in_weight), .in_ready(in_ready),
        .upd_q(upd_q), .upd_set(upd_set), .spike(spike), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One update: start, then offer weights per pat (1 after npat cycles), observe 30 cycles.
    task automatic run(input logic signed [20:0] sv, input logic signed [20:0] w,
                       input logic [5:0] pat, input int npat, input bit extra,
                       output int lat, output int sets, output int hs, output int last,
                       output logic signed [20:0] q, output logic spk);
        sets = 0; hs = 0; lat = -1; last = -1; q = '0; spk = 1'b0;
        @(negedge clk);
        stored_v = sv;
        start = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            if (upd_set) begin
                sets++;
                lat = e;
                q = upd_q;
                spk = spike;
            end
            start = extra && e == 2;
            in_valid = e < npat ? pat[e] : 1'b1;
            in_weight = w;
            if (in_valid && in_ready) begin
                hs++;
                last = e + 1;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_run(input string name, input vec_t v, input logic [5:0] pat,
                             input int npat, input bit extra, input int exp_lat);
        int lat, sets, hs, last;
        logic signed [20:0] q;
        logic spk;
        run(v.sv, v.w, pat, npat, extra, lat, sets, hs, last, q, spk);
        chk({name, " upd_q"}, q, v.q);
        chk({name, " spike"}, spk, v.spk);
        chk({name, " upd_set pulses"}, sets, 1);
        chk({name, " handshakes"}, hs, 4);
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " last-weight+2"}, lat, last + 2);
        chk({name, " upd_q held"}, upd_q, v.q);
        chk({name, " busy idle"}, busy, 0);
    endtask

    initial begin
        vec_t vecs[4];
        vecs[0] = '{sv: 21'sd0,        w: 21'sd512,   q: 21'sd1920,    spk: 1'b0};
        vecs[1] = '{sv: 21'sd7680,     w: 21'sd512,   q: 21'sd0,       spk: 1'b1};
        vecs[2] = '{sv: 21'sd1048000,  w: 21'sd1000,  q: 21'sd0,       spk: 1'b1};
        vecs[3] = '{sv: -21'sd1048000, w: -21'sd1000, q: -21'sd983040, spk: 1'b0};

        #2 rst = 1'b1;
        #1;
        chk("reset upd_q", upd_q, 0);
        chk("reset upd_set", upd_set, 0);
        chk("reset spike", spike, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle after reset", busy, 0);

        for (int i = 0; i < 4; i++)
            check_run($sformatf("vec%0d", i), vecs[i], 6'b111111, 0, 1'b0, 6);

        check_run("stall", vecs[0], 6'b111001, 6, 1'b1, 8);

        begin
            int sets = 0;
            @(negedge clk);
            stored_v = 21'sd0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b1;
            in_weight = 21'sd512;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            #1;
            chk("abort busy", busy, 0);
            chk("abort in_ready", in_ready, 0);
            chk("abort upd_q", upd_q, 0);
            chk("abort upd_set", upd_set, 0);
            for (int e = 0; e < 10; e++) begin
                @(negedge clk);
                if (e == 2) rst = 1'b0;
                if (upd_set) sets++;
            end
            in_valid = 1'b0;
            chk("abort no upd_set", sets, 0);
            chk("abort idle", busy, 0);
        end

        check_run("post-abort", vecs[0], 6'b111111, 0, 1'b0, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
